// File: rtl/coin_pkg.sv
// Shared types and default constants for the coin sensor front-end.
package coin_pkg;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned CNT_W_DEF           = 5;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_GAP  = 1'b1
  } arb_state_e;

  // Registered pulse bundle handed to the vending FSM.
  typedef struct packed {
    logic load50;
    logic load100;
    logic err;
  } coin_pulse_t;

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: multi-flop synchroniser, counter debounce and rising-edge
// detect on the debounced level.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise_c
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   r_stable_d;

  logic w_sync;
  logic w_diff;
  logic w_flip;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_diff = w_sync ^ r_stable;
  assign w_flip = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt    <= '0;
        r_stable <= ~r_stable;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise_c = r_stable & ~r_stable_d;

endmodule

// File: rtl/coin_pulse_gen.sv
// Coin sensor front-end: two debounced channels feeding a pending/arbiter stage
// that emits isolated single-cycle load pulses for the vending FSM.
module coin_pulse_gen
  import coin_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic coin50_raw,
  input  logic coin100_raw,
  input  logic enable,
  output logic load50bani,
  output logic load1leu,
  output logic coin_err
);

  logic w_stable50;
  logic w_stable100;
  logic w_rise50;
  logic w_rise100;
  logic w_unused_stable;
  logic w_req50;
  logic w_req100;

  arb_state_e  r_state;
  arb_state_e  w_state_nxt;
  logic        r_pend50;
  logic        r_pend100;
  logic        w_pend50_nxt;
  logic        w_pend100_nxt;
  coin_pulse_t r_out;
  coin_pulse_t w_out_nxt;

  coin_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb50 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (coin50_raw),
    .o_stable(w_stable50),
    .o_rise_c(w_rise50)
  );

  coin_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb100 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (coin100_raw),
    .o_stable(w_stable100),
    .o_rise_c(w_rise100)
  );

  assign w_unused_stable = w_stable50 & w_stable100;

  assign w_req50  = w_rise50  | r_pend50;
  assign w_req100 = w_rise100 | r_pend100;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_pend50  <= 1'b0;
      r_pend100 <= 1'b0;
      r_out     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend50  <= w_pend50_nxt;
      r_pend100 <= w_pend100_nxt;
      r_out     <= w_out_nxt;
    end
  end

  // 50 bani has priority; every pulse is followed by a forced GAP cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_pend50_nxt  = r_pend50;
    w_pend100_nxt = r_pend100;
    w_out_nxt     = '0;

    if (!enable) begin
      w_state_nxt   = ARB_IDLE;
      w_pend50_nxt  = 1'b0;
      w_pend100_nxt = 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_req50) begin
            w_out_nxt.load50 = 1'b1;
            w_pend50_nxt     = 1'b0;
            w_state_nxt      = ARB_GAP;
          end else if (w_req100) begin
            w_out_nxt.load100 = 1'b1;
            w_pend100_nxt     = 1'b0;
            w_state_nxt       = ARB_GAP;
          end
        end
        ARB_GAP: begin
          w_state_nxt = ARB_IDLE;
        end
        default: begin
          w_state_nxt = ARB_IDLE;
        end
      endcase

      // An unserved rise on an already-pending channel loses one coin.
      if (w_rise50 && !w_out_nxt.load50) begin
        if (r_pend50) begin
          w_out_nxt.err = 1'b1;
        end
        w_pend50_nxt = 1'b1;
      end
      if (w_rise100 && !w_out_nxt.load100) begin
        if (r_pend100) begin
          w_out_nxt.err = 1'b1;
        end
        w_pend100_nxt = 1'b1;
      end
    end
  end

  assign load50bani = r_out.load50;
  assign load1leu   = r_out.load100;
  assign coin_err   = r_out.err;

endmodule

// File: tb/tb_coin_pulse_gen.sv
// Scoreboard bench for coin_pulse_gen: expected pulses (cycle, kind) are queued
// when stimulus is driven and compared against pulses recorded on the outputs.
module tb_coin_pulse_gen;

  localparam int unsigned LAT = 19;
  localparam int K50  = 0;
  localparam int K100 = 1;
  localparam int KERR = 2;

  typedef struct {
    int unsigned cyc;
    int          kind;
  } ev_t;

  logic clk;
  logic rst_n;
  logic coin50_raw;
  logic coin100_raw;
  logic enable;
  logic load50bani;
  logic load1leu;
  logic coin_err;

  int unsigned cyc;
  int unsigned both_cnt;
  int          n_checks;
  int          n_fail;
  ev_t         exp_q[$];
  ev_t         obs_q[$];
  ev_t         e;
  ev_t         o;

  coin_pulse_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin50_raw (coin50_raw),
    .coin100_raw(coin100_raw),
    .enable     (enable),
    .load50bani (load50bani),
    .load1leu   (load1leu),
    .coin_err   (coin_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse with the cycle it was seen in.
  initial both_cnt = 0;
  always @(negedge clk) begin
    if (load50bani === 1'b1) obs_q.push_back('{cyc, K50});
    if (load1leu === 1'b1)   obs_q.push_back('{cyc, K100});
    if (coin_err === 1'b1)   obs_q.push_back('{cyc, KERR});
    if (load50bani === 1'b1 && load1leu === 1'b1) both_cnt = both_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; coin50_raw = 1'b0; coin100_raw = 1'b0; enable = 1'b1;
    idle(4);
    n_checks++;
    if (load50bani !== 1'b0) begin n_fail++; $display("FAIL reset_load50: got %b expected 0", load50bani); end
    n_checks++;
    if (load1leu !== 1'b0) begin n_fail++; $display("FAIL reset_load1leu: got %b expected 0", load1leu); end
    n_checks++;
    if (coin_err !== 1'b0) begin n_fail++; $display("FAIL reset_coin_err: got %b expected 0", coin_err); end
    rst_n = 1'b1;
    idle(5);
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_quiet: got %0d pulses expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_coin50();
    exp_q.push_back('{cyc + LAT, K50});
    coin50_raw = 1'b1;
    idle(40);
    coin50_raw = 1'b0;
    idle(25);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL coin50 count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.kind !== e.kind || o.cyc !== e.cyc) begin n_fail++; $display("FAIL coin50 pulse: got kind %0d cyc %0d expected kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bounce100();
    for (int i = 0; i < 4; i++) begin
      coin100_raw = (i % 2 == 0) ? 1'b1 : 1'b0;
      idle(3);
    end
    exp_q.push_back('{cyc + LAT, K100});
    coin100_raw = 1'b1;
    idle(40);
    coin100_raw = 1'b0;
    idle(25);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bounce100 count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.kind !== e.kind || o.cyc !== e.cyc) begin n_fail++; $display("FAIL bounce100 pulse: got kind %0d cyc %0d expected kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_simultaneous();
    exp_q.push_back('{cyc + LAT, K50});
    exp_q.push_back('{cyc + LAT + 2, K100});
    coin50_raw = 1'b1; coin100_raw = 1'b1;
    idle(40);
    coin50_raw = 1'b0; coin100_raw = 1'b0;
    idle(25);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL simultaneous count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.kind !== e.kind || o.cyc !== e.cyc) begin n_fail++; $display("FAIL simultaneous pulse: got kind %0d cyc %0d expected kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch();
    // 10 and 15 cycle glitches are rejected; 16 is accepted.
    coin50_raw = 1'b1; idle(10); coin50_raw = 1'b0; idle(30);
    coin50_raw = 1'b1; idle(15); coin50_raw = 1'b0; idle(30);
    exp_q.push_back('{cyc + LAT, K50});
    coin50_raw = 1'b1; idle(16); coin50_raw = 1'b0; idle(40);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL glitch count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.kind !== e.kind || o.cyc !== e.cyc) begin n_fail++; $display("FAIL glitch pulse: got kind %0d cyc %0d expected kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_enable();
    enable = 1'b0;
    coin50_raw = 1'b1;
    idle(40);
    enable = 1'b1;
    idle(30);
    coin50_raw = 1'b0;
    idle(30);
    exp_q.push_back('{cyc + LAT, K50});
    coin50_raw = 1'b1;
    idle(40);
    coin50_raw = 1'b0;
    idle(25);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL enable count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.kind !== e.kind || o.cyc !== e.cyc) begin n_fail++; $display("FAIL enable pulse: got kind %0d cyc %0d expected kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_debounce();
    coin100_raw = 1'b1;
    idle(10);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({load50bani, load1leu, coin_err} !== 3'b000) begin n_fail++; $display("FAIL mid_debounce_outputs: got %b expected 000", {load50bani, load1leu, coin_err}); end
    idle(3);
    exp_q.push_back('{cyc + LAT, K100});
    rst_n = 1'b1;
    idle(40);
    coin100_raw = 1'b0;
    idle(25);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_debounce count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.kind !== e.kind || o.cyc !== e.cyc) begin n_fail++; $display("FAIL mid_debounce pulse: got kind %0d cyc %0d expected kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_pulse();
    exp_q.push_back('{cyc + LAT, K50});
    coin50_raw = 1'b1;
    idle(LAT);
    n_checks++;
    if (load50bani !== 1'b1) begin n_fail++; $display("FAIL mid_pulse_high: got %b expected 1", load50bani); end
    #2 rst_n = 1'b0;
    coin50_raw = 1'b0;
    #1;
    n_checks++;
    if (load50bani !== 1'b0) begin n_fail++; $display("FAIL mid_pulse_cleared: got %b expected 0", load50bani); end
    idle(3);
    rst_n = 1'b1;
    idle(40);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_pulse count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o.kind !== e.kind || o.cyc !== e.cyc) begin n_fail++; $display("FAIL mid_pulse pulse: got kind %0d cyc %0d expected kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (both_cnt != 0) begin n_fail++; $display("FAIL exclusive: got %0d cycles with both pulses expected 0", both_cnt); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_coin50();
    test_bounce100();
    test_simultaneous();
    test_glitch();
    test_enable();
    test_reset_mid_debounce();
    test_reset_mid_pulse();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_pulse_gen.md
Name: coin_pulse_gen

Overview:
Upstream front-end of the chocolate vending FSM. Takes the two raw, asynchronous, bouncy coin-sensor lines (50 bani, 1 leu), synchronises and debounces each one, and detects inserted coins. It then issues clean single-cycle load50bani / load1leu pulses that the vending FSM samples directly. Two pulses are never asserted in the same cycle, and consecutive pulses are always separated by at least one idle cycle.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each input synchroniser (>=2).
DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples required to accept a level change (>=2).
CNT_W, 5, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
coin50_raw  in  1  raw 50-bani sensor; asynchronous, may bounce.
coin100_raw  in  1  raw 1-leu sensor; asynchronous, may bounce.
enable  in  1  1 = accepting coins; 0 = out of service.
load50bani  out  1  one-cycle pulse, one per accepted 50-bani coin.
load1leu  out  1  one-cycle pulse, one per accepted 1-leu coin.
coin_err  out  1  one-cycle pulse when a coin is lost through pending overrun.

Behaviour:
- Reset (async assert, sync release): synchroniser flops, debounce counters, stable levels, pending flags, arbiter state and all outputs go to 0. Arbiter state goes to IDLE.
- Per-channel pipeline, identical for both channels:
  - SYNC_STAGES-deep synchroniser.
  - Debounce stage with `stable` register and counter.
    - If sync != stable: counter increments.
    - When counter == DEBOUNCE_CYCLES-1 and sync != stable: stable toggles and counter clears.
    - If sync == stable: counter clears.
  - rise = stable & ~stable_d (stable_d is stable delayed by 1 cycle).
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no change in stable.
- Latency: raw held high, first sampled at edge 1 → load pulse is high for exactly the cycle after edge L, where L = SYNC_STAGES + DEBOUNCE_CYCLES + 1 (19 with defaults). The falling edge of raw never generates a pulse.
- Pending flags pend50 / pend100 hold requests that cannot be served immediately. req_x = rise_x | pend_x.
- Arbiter, two states (outputs registered):
  - IDLE:
    - If req50: load50bani <= 1, clear pend50, go to GAP.
    - Else if req100: load1leu <= 1, clear pend100, go to GAP.
    - Else: outputs 0, stay in IDLE.
  - GAP: outputs <= 0, go to IDLE.
  - A rise not served in the current cycle sets its pend flag.
- Simultaneous rises on both channels: 50 bani is served first. 1 leu is served 2 cycles later (the GAP cycle in between).
- Overrun: a rise on a channel whose pend flag is already set and which is not being served this cycle → coin_err pulses 1 cycle, pend stays 1 (net loss of one coin).
- enable = 0:
  - Rises are discarded, not pended.
  - Pending flags clear on the next edge.
  - Arbiter outputs 0 and returns to IDLE.
  - Debounce continues running, so stable tracks the input and re-enable does not fake a rise.
- Raw input held high through reset release: stable starts at 0, so exactly one pulse is produced after L cycles (a stuck coin is counted once).
- Reset asserted mid-pulse or mid-debounce: everything clears immediately, with no pulse after release unless the raw line is still high.

Decomposition:
- Shared package coin_pkg: arbiter state enum (ARB_IDLE, ARB_GAP) and default constants for SYNC_STAGES / DEBOUNCE_CYCLES.
- One natural sub-module, coin_debounce (synchroniser + debounce + rise detect, with outputs stable and rise), instantiated once per channel.
- Pending flags, arbiter and error logic live in the top-level coin_pulse_gen.

Test Plan:
- Reset, then coin50_raw held high 40 cycles (defaults) → exactly one load50bani pulse at cycle 19; load1leu and coin_err stay 0.
- coin100_raw bounces (1-0-1-0, 3 cycles per level) then holds high → exactly one load1leu pulse, 19 cycles after the final stable rise; the falling edge produces no pulse.
- Both raw lines rise on the same cycle → load50bani at cycle 19, load1leu at cycle 21, never both high together.
- Glitch on coin50_raw of 10 cycles → no pulse. Glitch of 16 synchronised cycles → one pulse.
- enable = 0 during a coin50 rise → no pulse; enable -> 1 with the line still high → no pulse; next genuine coin is accepted normally.
- rst_n pulsed low while coin100 is 10 cycles into debounce → outputs 0 immediately; line still high after release → one load1leu at 19 cycles after release.
